// File: rtl/ycbcr_pkg.sv
// Shared types, colour-matrix table and saturation helpers for rgb_to_ycbcr_pipe.
package ycbcr_pkg;

  typedef enum logic [1:0] {
    YCC_BT601_STUDIO = 2'd0,
    YCC_BT601_FULL   = 2'd1,
    YCC_BT709_STUDIO = 2'd2
  } ycc_mode_t;

  typedef logic signed [8:0] coef_t;

  typedef struct packed {
    coef_t      yr;
    coef_t      yg;
    coef_t      yb;
    coef_t      cbr;
    coef_t      cbg;
    coef_t      cbb;
    coef_t      crr;
    coef_t      crg;
    coef_t      crb;
    logic [7:0] y_off;
  } ycc_matrix_t;

  // Q0.8 coefficients in R, G, B order; y_off is in 8-bit output units.
  localparam ycc_matrix_t YCC_MATRIX [3] = '{
    '{ 9'sd66,  9'sd129,  9'sd25, -9'sd38, -9'sd74, 9'sd112, 9'sd112,  -9'sd94, -9'sd18, 8'd16 },
    '{ 9'sd77,  9'sd150,  9'sd29, -9'sd43, -9'sd85, 9'sd128, 9'sd128, -9'sd107, -9'sd21, 8'd0  },
    '{ 9'sd47,  9'sd157,  9'sd16, -9'sd26, -9'sd87, 9'sd112, 9'sd112, -9'sd102, -9'sd10, 8'd16 }
  };

  // The reserved encoding falls back to BT.601 studio.
  function automatic ycc_matrix_t ycc_lookup(input logic [1:0] mode);
    case (mode)
      YCC_BT601_FULL:   return YCC_MATRIX[1];
      YCC_BT709_STUDIO: return YCC_MATRIX[2];
      default:          return YCC_MATRIX[0];
    endcase
  endfunction

  function automatic logic is_studio(input logic [1:0] mode);
    return (mode != YCC_BT601_FULL);
  endfunction

  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                    input logic signed [31:0] lo,
                                                    input logic signed [31:0] hi);
    if (v < lo)
      return lo;
    else if (v > hi)
      return hi;
    else
      return v;
  endfunction

  function automatic logic [31:0] sat_unsigned(input logic signed [31:0] v,
                                               input logic signed [31:0] lo,
                                               input logic signed [31:0] hi);
    if (v < lo)
      return lo;
    else if (v > hi)
      return hi;
    else
      return v;
  endfunction

endpackage

// File: rtl/ycc_dot3.sv
// Registered 3-term signed dot product with round-half-up scaling by 2^-SH.
module ycc_dot3
  import ycbcr_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SH     = 8,
  parameter int SW     = DATA_W + 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [DATA_W-1:0]    a,
  input  logic [DATA_W-1:0]    b,
  input  logic [DATA_W-1:0]    c,
  input  coef_t                ka,
  input  coef_t                kb,
  input  coef_t                kc,
  output logic signed [SW-1:0] rounded
);

  localparam int PW = DATA_W + 9;
  localparam logic signed [SW-1:0] RND = SW'(1) << (SH - 1);

  logic signed [PW-1:0] prod_a;
  logic signed [PW-1:0] prod_b;
  logic signed [PW-1:0] prod_c;
  logic signed [SW-1:0] sum_d;
  logic signed [SW-1:0] sum_q;

  // Pixels are zero-extended so they multiply as non-negative signed values.
  assign prod_a = PW'($signed({1'b0, a})) * PW'(ka);
  assign prod_b = PW'($signed({1'b0, b})) * PW'(kb);
  assign prod_c = PW'($signed({1'b0, c})) * PW'(kc);
  assign sum_d  = SW'(prod_a) + SW'(prod_b) + SW'(prod_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sum_q <= '0;
    else if (en)
      sum_q <= sum_d;
  end

  assign rounded = (sum_q + RND) >>> SH;

endmodule

// File: rtl/rgb_to_ycbcr_pipe.sv
// Three-stage RGB to YCbCr converter with valid/ready handshake and per-pixel matrix select.
// Define RGB2YCBCR_STUDIO_CLAMP_EN to clamp studio-range modes (0 and 2) to nominal studio levels.
module rgb_to_ycbcr_pipe
  import ycbcr_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8,
  parameter int USER_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_g,
  input  logic [DATA_W-1:0] in_b,
  input  logic [1:0]        in_mode,
  input  logic [USER_W-1:0] in_user,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_y,
  output logic [OUT_W-1:0]  out_cb,
  output logic [OUT_W-1:0]  out_cr,
  output logic [USER_W-1:0] out_user
);

  localparam int SH = 8 + DATA_W - OUT_W;
  localparam int SW = DATA_W + 11;
  localparam int SC = OUT_W - 8;

  localparam logic signed [31:0] Y_MAX = 32'((1 << OUT_W) - 1);
  localparam logic signed [31:0] C_MIN = -32'(1 << (OUT_W - 1));
  localparam logic signed [31:0] C_MAX = 32'((1 << (OUT_W - 1)) - 1);

  logic adv;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_r;
  logic [DATA_W-1:0] s1_g;
  logic [DATA_W-1:0] s1_b;
  ycc_matrix_t       s1_mat;
  logic [USER_W-1:0] s1_user;

  logic              s2_valid;
  logic [7:0]        s2_yoff;
  logic [USER_W-1:0] s2_user;

  logic signed [SW-1:0] y_round;
  logic signed [SW-1:0] cb_round;
  logic signed [SW-1:0] cr_round;

  logic signed [31:0] y_lo;
  logic signed [31:0] y_hi;
  logic signed [31:0] c_lo;
  logic signed [31:0] c_hi;
  logic [OUT_W-1:0]   y_next;
  logic [OUT_W-1:0]   cb_next;
  logic [OUT_W-1:0]   cr_next;

  // One global enable: every stage moves together, so bubbles keep their slots.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_mat   <= '0;
      s1_user  <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_r     <= in_r;
      s1_g     <= in_g;
      s1_b     <= in_b;
      s1_mat   <= ycc_lookup(in_mode);
      s1_user  <= in_user;
    end
  end

  ycc_dot3 #(.DATA_W(DATA_W), .SH(SH), .SW(SW)) u_dot_y (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (adv),
    .a       (s1_r),
    .b       (s1_g),
    .c       (s1_b),
    .ka      (s1_mat.yr),
    .kb      (s1_mat.yg),
    .kc      (s1_mat.yb),
    .rounded (y_round)
  );

  ycc_dot3 #(.DATA_W(DATA_W), .SH(SH), .SW(SW)) u_dot_cb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (adv),
    .a       (s1_r),
    .b       (s1_g),
    .c       (s1_b),
    .ka      (s1_mat.cbr),
    .kb      (s1_mat.cbg),
    .kc      (s1_mat.cbb),
    .rounded (cb_round)
  );

  ycc_dot3 #(.DATA_W(DATA_W), .SH(SH), .SW(SW)) u_dot_cr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (adv),
    .a       (s1_r),
    .b       (s1_g),
    .c       (s1_b),
    .ka      (s1_mat.crr),
    .kb      (s1_mat.crg),
    .kc      (s1_mat.crb),
    .rounded (cr_round)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_yoff  <= '0;
      s2_user  <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_yoff  <= s1_mat.y_off;
      s2_user  <= s1_user;
    end
  end

`ifdef RGB2YCBCR_STUDIO_CLAMP_EN
  logic s1_studio;
  logic s2_studio;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_studio <= 1'b0;
      s2_studio <= 1'b0;
    end else if (adv) begin
      s1_studio <= is_studio(in_mode);
      s2_studio <= s1_studio;
    end
  end
`endif

  always_comb begin
    y_lo = '0;
    y_hi = Y_MAX;
    c_lo = C_MIN;
    c_hi = C_MAX;
`ifdef RGB2YCBCR_STUDIO_CLAMP_EN
    if (s2_studio) begin
      y_lo = 32'(16 << SC);
      y_hi = 32'(235 << SC);
      c_lo = -32'(112 << SC);
      c_hi = 32'(112 << SC);
    end
`endif
    y_next  = OUT_W'(sat_unsigned($signed(32'(y_round)) + $signed(32'(s2_yoff) << SC), y_lo, y_hi));
    cb_next = OUT_W'(sat_signed($signed(32'(cb_round)), c_lo, c_hi));
    cr_next = OUT_W'(sat_signed($signed(32'(cr_round)), c_lo, c_hi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_cb    <= '0;
      out_cr    <= '0;
      out_user  <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      out_y     <= y_next;
      out_cb    <= cb_next;
      out_cr    <= cr_next;
      out_user  <= s2_user;
    end
  end

endmodule

// File: tb/tb_rgb_to_ycbcr_pipe.sv
// Self-checking bench for rgb_to_ycbcr_pipe: directed vectors, backpressure, reset and random traffic
// scored against an arithmetic reference model.
module tb_rgb_to_ycbcr_pipe;

  localparam int DATA_W = 8;
  localparam int OUT_W  = 8;
  localparam int USER_W = 2;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_r;
  logic [DATA_W-1:0] in_g;
  logic [DATA_W-1:0] in_b;
  logic [1:0]        in_mode;
  logic [USER_W-1:0] in_user;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_y;
  logic [OUT_W-1:0]  out_cb;
  logic [OUT_W-1:0]  out_cr;
  logic [USER_W-1:0] out_user;

  typedef struct {
    logic [OUT_W-1:0]  y;
    logic [OUT_W-1:0]  cb;
    logic [OUT_W-1:0]  cr;
    logic [USER_W-1:0] user;
    int                cyc;
    bit                lat;
  } entry_t;

  entry_t exp_q[$];
  int     checks;
  int     errors;
  int     cyc;
  bit     last_acc;
  int     sent;
  int     bp_r [8];
  int     bp_g [8];
  int     bp_b [8];

  int coef_tab [3][9] = '{
    '{66, 129, 25, -38, -74, 112, 112,  -94, -18},
    '{77, 150, 29, -43, -85, 128, 128, -107, -21},
    '{47, 157, 16, -26, -87, 112, 112, -102, -10}
  };
  int yoff_tab [3] = '{16, 0, 16};

  rgb_to_ycbcr_pipe #(.DATA_W(DATA_W), .OUT_W(OUT_W), .USER_W(USER_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_g      (in_g),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .in_user   (in_user),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_cb    (out_cb),
    .out_cr    (out_cr),
    .out_user  (out_user)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Reference conversion straight from the matrix definition, in plain integer arithmetic.
  function automatic void model(input int r, input int g, input int b, input int mode,
                                output int y, output int cb, output int cr);
    int m;
    int sh;
    int half;
    int sc;
    m    = (mode == 3) ? 0 : mode;
    sh   = 8 + DATA_W - OUT_W;
    half = 1 << (sh - 1);
    sc   = 1 << (OUT_W - 8);
    y  = ((coef_tab[m][0] * r + coef_tab[m][1] * g + coef_tab[m][2] * b + half) >>> sh) + yoff_tab[m] * sc;
    cb = (coef_tab[m][3] * r + coef_tab[m][4] * g + coef_tab[m][5] * b + half) >>> sh;
    cr = (coef_tab[m][6] * r + coef_tab[m][7] * g + coef_tab[m][8] * b + half) >>> sh;
    y  = clampi(y, 0, (1 << OUT_W) - 1);
    cb = clampi(cb, -(1 << (OUT_W - 1)), (1 << (OUT_W - 1)) - 1);
    cr = clampi(cr, -(1 << (OUT_W - 1)), (1 << (OUT_W - 1)) - 1);
`ifdef RGB2YCBCR_STUDIO_CLAMP_EN
    if (m != 1) begin
      y  = clampi(y, 16 * sc, 235 * sc);
      cb = clampi(cb, -112 * sc, 112 * sc);
      cr = clampi(cr, -112 * sc, 112 * sc);
    end
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      $error("[TB] check %s", tag);
    end
  endtask

  // One clock cycle: drive at the falling edge, score outputs, record any accepted pixel.
  task automatic applyStimulus(input bit v, input int r, input int g, input int b, input int mode,
                               input int user, input bit ordy, input bit lat,
                               input bit has_exp = 1'b0, input int ey = 0, input int ecb = 0,
                               input int ecr = 0);
    entry_t e;
    int my;
    int mcb;
    int mcr;
    in_valid  = v;
    in_r      = DATA_W'(r);
    in_g      = DATA_W'(g);
    in_b      = DATA_W'(b);
    in_mode   = 2'(mode);
    in_user   = USER_W'(user);
    out_ready = ordy;
    #1;
    last_acc = in_valid && in_ready;
    if (exp_q.size() == 0)
      checkOutput("idle_valid", 32'(out_valid), 32'd0);
    if (ordy)
      checkOutput("in_ready_open", 32'(in_ready), 32'd1);
    else if (out_valid)
      checkOutput("in_ready_stall", 32'(in_ready), 32'd0);
    if (out_valid && exp_q.size() > 0) begin
      e = exp_q[0];
      checkOutput("out_y", 32'(out_y), 32'(e.y));
      checkOutput("out_cb", 32'(out_cb), 32'(e.cb));
      checkOutput("out_cr", 32'(out_cr), 32'(e.cr));
      checkOutput("out_user", 32'(out_user), 32'(e.user));
      if (ordy) begin
        if (e.lat)
          checkOutput("latency", 32'(cyc - e.cyc), 32'd3);
        void'(exp_q.pop_front());
      end
    end
    if (last_acc) begin
      if (has_exp) begin
        my  = ey;
        mcb = ecb;
        mcr = ecr;
      end else begin
        model(r, g, b, mode, my, mcb, mcr);
      end
      e.y    = OUT_W'(my);
      e.cb   = OUT_W'(mcb);
      e.cr   = OUT_W'(mcr);
      e.user = USER_W'(user);
      e.cyc  = cyc;
      e.lat  = lat;
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    last_acc  = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_r      = '0;
    in_g      = '0;
    in_b      = '0;
    in_mode   = '0;
    in_user   = '0;
    out_ready = 1'b1;

    #3;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_y", 32'(out_y), 32'd0);
    checkOutput("rst_out_cb", 32'(out_cb), 32'd0);
    checkOutput("rst_out_cr", 32'(out_cr), 32'd0);
    checkOutput("rst_out_user", 32'(out_user), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed vectors");
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 1, 1, 16, 0, 0);
    applyStimulus(1, 255, 255, 255, 0, 2, 1, 1, 1, 235, 0, 0);
    applyStimulus(1, 255, 0, 0, 0, 3, 1, 1, 1, 82, -38, 112);
    applyStimulus(1, 0, 0, 255, 1, 0, 1, 1, 1, 29, 127, -21);
    applyStimulus(1, 255, 255, 255, 1, 1, 1, 1);
    applyStimulus(1, 0, 0, 0, 2, 2, 1, 1);
    applyStimulus(1, 255, 255, 255, 2, 3, 1, 1);
    applyStimulus(1, 255, 0, 0, 3, 0, 1, 1);
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);

    $display("[TB] alternating modes 0/2 on green");
    for (int i = 0; i < 10; i++)
      applyStimulus(1, 0, 255, 0, (i % 2 == 1) ? 2 : 0, i, 1, 1);
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);

    $display("[TB] backpressure");
    for (int i = 0; i < 8; i++) begin
      bp_r[i] = int'($urandom_range(0, 255));
      bp_g[i] = int'($urandom_range(0, 255));
      bp_b[i] = int'($urandom_range(0, 255));
    end
    sent = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(sent < 8, bp_r[sent % 8], bp_g[sent % 8], bp_b[sent % 8], sent % 3, sent,
                    !(k >= 4 && k < 9), 0);
      if (last_acc)
        sent++;
    end
    checkOutput("bp_sent", 32'(sent), 32'd8);
    checkOutput("bp_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] reset with pixels in flight");
    for (int i = 0; i < 3; i++)
      applyStimulus(1, int'($urandom_range(1, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), i, i + 1, 1, 1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_y", 32'(out_y), 32'd0);
    checkOutput("midrst_out_cb", 32'(out_cb), 32'd0);
    checkOutput("midrst_out_cr", 32'(out_cr), 32'd0);
    checkOutput("midrst_out_user", 32'(out_user), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);

    $display("[TB] random traffic");
    for (int k = 0; k < 300; k++)
      applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    $urandom_range(0, 9) < 7, 0);
    repeat (6) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);

    $display("[TB] full-rate stream");
    for (int k = 0; k < 30; k++) begin
      applyStimulus(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 1, 1);
      checkOutput("full_rate_accept", 32'(last_acc), 32'd1);
    end
    repeat (6) applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("final_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
